afu_cfg0_responder: RTL and testbench
=====================================

// Module: afu_cfg0_responder
// PURPOSE
//  AFU-side endpoint of the TLX cfg0 channel. Queues config read/write commands from the TLX, executes them
//  against a local 32-bit register file, and returns cfg0 responses with the TLX response-ack handshake.
//  Owns cfg0 command-credit flow control. Sits between the TLX model/bench and the AFU config logic.
// PARAMETERS
//  FIFO_DEPTH  4            cmd queue depth = credits advertised; 1..15
//  NUM_REGS    16           32-bit registers; word index = pa[11:2]
//  ID_VALUE    32'h1014_0632 read-only contents of reg 0
// PORTS
//  tlx_clock                  in   1    sole clock
//  reset_n                    in   1    async active-low reset
//  tlx_cfg0_valid             in   1    cmd strobe, one cycle per cmd
//  tlx_cfg0_opcode            in   8    8'hE0 config_read, 8'hE1 config_write
//  tlx_cfg0_pa                in   64   address; [11:2] word, [1:0] byte
//  tlx_cfg0_t                 in   1    0=type0 (served), 1=type1 (fails)
//  tlx_cfg0_pl                in   3    0=1B 1=2B 2=4B, others illegal
//  tlx_cfg0_capptag           in   16   tag echoed in response
//  tlx_cfg0_data_bus          in   32   write data, same cycle as valid
//  tlx_cfg0_data_bdi          in   1    write data bad
//  tlx_cfg0_resp_ack          in   1    TLX accepted the presented response
//  cfg0_tlx_initial_credit    out  4    constant FIFO_DEPTH
//  cfg0_tlx_credit_return     out  1    one-cycle pulse per FIFO pop
//  cfg0_tlx_resp_valid        out  1    response presented, held to ack
//  cfg0_tlx_resp_opcode       out  8    01 rd_resp, 02 rd_fail, 04 wr_resp, 05 wr_fail
//  cfg0_tlx_resp_capptag      out  16   echoed tag
//  cfg0_tlx_resp_code         out  4    0 on success, else fail code
//  cfg0_tlx_rdata_offset      out  4    {2'b0, pa[1:0]} on reads, 0 otherwise
//  cfg0_tlx_rdata_bus         out  32   full register word on rd_resp, else 0
//  cfg0_tlx_rdata_bdi         out  1    always 0
//  cfg_regs                   out  NUM_REGS*32  flattened register file, reg0 in [31:0]
//  protocol_err               out  1    sticky: cmd received while FIFO full
// BEHAVIOUR
//  Reset: all outputs 0 except initial_credit=FIFO_DEPTH and cfg_regs[31:0]=ID_VALUE; FIFO empty; FSM IDLE.
//  Capture: valid && !full -> push {opcode,pa[11:0],t,pl,capptag,data,bdi} same cycle. valid && full -> drop, set protocol_err.
//  FSM IDLE: FIFO non-empty -> pop, pulse credit_return that cycle -> EXEC.
//  EXEC (1 cycle): check in order (first hit wins):
//   opcode not E0/E1 -> rd_fail code 9
//   t=1 -> fail code E
//   pl>2 -> fail code 9
//   pa[1:0] misaligned for size -> fail code B
//   word>=NUM_REGS -> fail code E
//   write && bdi -> wr_fail code 8 (only with CFG0_BDI_CHECK_EN)
//   Else read returns reg word; write merges bytes (lane = pa[1:0]..+size-1) into reg. Reg 0 write: success, no update.
//   Register update and response registers load at end of EXEC -> RESP.
//  RESP: resp_valid=1, fields stable until resp_ack. ack -> resp_valid=0 next cycle, IDLE.
//   Min cmd->resp_valid latency 3 cycles from empty. Back-to-back throughput is 1 cmd per 3 cycles + ack wait.
//  Push and pop in the same cycle are legal at any occupancy, including full (pop frees a slot that cycle).
//  resp_ack outside RESP is ignored. Reset mid-op discards queued cmds and any pending response. No credit_return for them.
// CONFIGURATION
//  CFG0_BDI_CHECK_EN defined: a write with bdi=1 is answered wr_fail code 8, register unchanged.
//  Undefined: bdi is ignored and the write proceeds normally.
// STRUCTURE
//  Package cfg0_pkg holds:
//   - opcode and resp-code localparams
//   - state enum {IDLE,EXEC,RESP}
//   - packed struct cfg0_cmd_t for the FIFO entry
//  Sub-module cfg0_cmd_fifo: synchronous FIFO of cfg0_cmd_t, with full/empty flags and simultaneous push/pop.
// TESTING
//  1. Write E1 pa=0x004 pl=2 data=DEADBEEF -> wr_resp code 0, credit pulse. Read pa=0x004 -> rd_resp data DEADBEEF offset 0.
//  2. Write pl=0 pa=0x009 data=000000AA onto reg2=0 -> reg2=0000AA00. Read pa=0x00A pl=1 -> offset 2.
//  3. Read pa=0x040 (word16) -> rd_fail code E. Write pa=0x006 pl=2 -> wr_fail code B. Opcode 8'h20 -> rd_fail code 9.
//  4. Hold resp_ack low 10 cycles with 4 cmds queued -> response fields stable; a 5th valid sets protocol_err.
//     After acks, 4 credit pulses total.
//  5. Write bdi=1 to reg1: with CFG0_BDI_CHECK_EN -> wr_fail 8, reg1 unchanged; without -> wr_resp 0, reg1 updated.
//  6. Assert reset_n low while in RESP -> resp_valid 0 asynchronously, reg0=ID_VALUE, protocol_err 0, FIFO empty.

Source files
------------

// File: rtl/cfg0_pkg.sv
// cfg0_pkg: shared definitions for the TLX cfg0 responder.
//   - cfg0 command / response opcodes and response codes
//   - responder FSM state encoding
//   - cfg0_cmd_t: one queued cfg0 command
//   - helpers for size/alignment decode and byte-lane masks
package cfg0_pkg;

    localparam logic [7:0] OP_CONFIG_READ  = 8'hE0;
    localparam logic [7:0] OP_CONFIG_WRITE = 8'hE1;

    localparam logic [7:0] OP_RD_RESP = 8'h01;
    localparam logic [7:0] OP_RD_FAIL = 8'h02;
    localparam logic [7:0] OP_WR_RESP = 8'h04;
    localparam logic [7:0] OP_WR_FAIL = 8'h05;

    localparam logic [3:0] CODE_OK     = 4'h0;
    localparam logic [3:0] CODE_BAD_DATA = 4'h8;
    localparam logic [3:0] CODE_BAD_OP = 4'h9;
    localparam logic [3:0] CODE_ALIGN  = 4'hB;
    localparam logic [3:0] CODE_ADDR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } cfg0_state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [11:0] pa;
        logic        t;
        logic [2:0]  pl;
        logic [15:0] capptag;
        logic [31:0] data;
        logic        bdi;
    } cfg0_cmd_t;

    // Byte lanes touched by an access of size pl starting at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [2:0] pl, input logic [1:0] off);
        logic [3:0] base;
        case (pl)
            3'd0:    base = 4'b0001;
            3'd1:    base = 4'b0011;
            3'd2:    base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << off;
    endfunction

    // Natural alignment: 2-byte on even offsets, 4-byte on offset 0.
    function automatic logic is_aligned(input logic [2:0] pl, input logic [1:0] off);
        logic ok;
        case (pl)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~off[0];
            3'd2:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cfg0_cmd_fifo.sv
// cfg0_cmd_fifo: synchronous FIFO of cfg0_cmd_t entries.
// Ports:
//   clk, rst_n    clock, async active-low reset (FIFO emptied)
//   push, push_data  write an entry (accepted when not full, or when popping)
//   pop           remove head entry (ignored when empty)
//   head          current head entry
//   full, empty   occupancy flags
// A push and a pop in the same cycle are both honoured, even when full.
module cfg0_cmd_fifo
    import cfg0_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  cfg0_cmd_t push_data,
    input  logic      pop,
    output cfg0_cmd_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cfg0_cmd_t     mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [3:0]    count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign empty     = (count_r == 4'd0);
    assign full      = (count_r == 4'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push_ok_s = push && (!full || pop_ok_s);
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= 4'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/afu_cfg0_responder.sv
// afu_cfg0_responder: AFU endpoint of the TLX cfg0 channel.
// Queues config read/write commands, executes them one at a time against a
// local 32-bit register file, and returns one response per command, held
// until the TLX acknowledges it.
// Ports:
//   tlx_clock, reset_n        clock, async active-low reset
//   tlx_cfg0_*                incoming command (valid strobe + fields)
//   tlx_cfg0_resp_ack         TLX accepted the presented response
//   cfg0_tlx_initial_credit   command credits advertised (FIFO_DEPTH)
//   cfg0_tlx_credit_return    one pulse per command taken from the queue
//   cfg0_tlx_resp_*           response fields, stable while resp_valid
//   cfg0_tlx_rdata_*          read data, byte offset and bad-data flag
//   cfg_regs                  flattened register file, reg0 in [31:0]
//   protocol_err              sticky: command arrived with no free slot
// Build option: define CFG0_BDI_CHECK_EN to fail writes carrying bad data
// (wr_fail code 8, register untouched); otherwise bdi is ignored.
module afu_cfg0_responder
    import cfg0_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'h1014_0632
)(
    input  logic                  tlx_clock,
    input  logic                  reset_n,
    input  logic                  tlx_cfg0_valid,
    input  logic [7:0]            tlx_cfg0_opcode,
    input  logic [63:0]           tlx_cfg0_pa,
    input  logic                  tlx_cfg0_t,
    input  logic [2:0]            tlx_cfg0_pl,
    input  logic [15:0]           tlx_cfg0_capptag,
    input  logic [31:0]           tlx_cfg0_data_bus,
    input  logic                  tlx_cfg0_data_bdi,
    input  logic                  tlx_cfg0_resp_ack,
    output logic [3:0]            cfg0_tlx_initial_credit,
    output logic                  cfg0_tlx_credit_return,
    output logic                  cfg0_tlx_resp_valid,
    output logic [7:0]            cfg0_tlx_resp_opcode,
    output logic [15:0]           cfg0_tlx_resp_capptag,
    output logic [3:0]            cfg0_tlx_resp_code,
    output logic [3:0]            cfg0_tlx_rdata_offset,
    output logic [31:0]           cfg0_tlx_rdata_bus,
    output logic                  cfg0_tlx_rdata_bdi,
    output logic [NUM_REGS*32-1:0] cfg_regs,
    output logic                  protocol_err
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    cfg0_state_e state_r, state_next_s;
    cfg0_cmd_t   push_cmd_s, head_s, cmd_r;
    logic        full_s, empty_s, pop_s, push_s;
    logic [31:0] regs_r [NUM_REGS];

    logic [9:0]  word_s;
    logic [1:0]  off_s;
    logic        is_write_s, bdi_fail_s, fail_s, wr_en_s;
    logic [3:0]  code_s;
    logic [7:0]  resp_op_s;
    logic [31:0] rd_word_s, rdata_s, wr_data_s;
    logic [3:0]  wr_mask_s;

    logic        resp_valid_r, protocol_err_r;
    logic [7:0]  resp_op_r;
    logic [15:0] resp_tag_r;
    logic [3:0]  resp_code_r, rdata_off_r;
    logic [31:0] rdata_r;

    // Only pa[11:0] addresses the register window.
    logic unused_pa_s;
    assign unused_pa_s = ^tlx_cfg0_pa[63:12];

    assign push_cmd_s = '{opcode:  tlx_cfg0_opcode,
                          pa:      tlx_cfg0_pa[11:0],
                          t:       tlx_cfg0_t,
                          pl:      tlx_cfg0_pl,
                          capptag: tlx_cfg0_capptag,
                          data:    tlx_cfg0_data_bus,
                          bdi:     tlx_cfg0_data_bdi};

    assign pop_s  = (state_r == IDLE) && !empty_s;
    assign push_s = tlx_cfg0_valid && (!full_s || pop_s);

    cfg0_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (tlx_clock),
        .rst_n     (reset_n),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

`ifdef CFG0_BDI_CHECK_EN
    assign bdi_fail_s = is_write_s && cmd_r.bdi;
`else
    logic unused_bdi_s;
    assign unused_bdi_s = cmd_r.bdi;
    assign bdi_fail_s   = 1'b0;
`endif

    assign word_s     = cmd_r.pa[11:2];
    assign off_s      = cmd_r.pa[1:0];
    assign is_write_s = (cmd_r.opcode == OP_CONFIG_WRITE);
    assign rd_word_s  = regs_r[word_s[IW-1:0]];
    assign wr_data_s  = cmd_r.data << {off_s, 3'b000};
    assign wr_mask_s  = lane_mask(cmd_r.pl, off_s);

    // Command checks, first failing check decides the response code.
    always_comb begin
        fail_s = 1'b1;
        code_s = CODE_OK;
        if ((cmd_r.opcode != OP_CONFIG_READ) && !is_write_s) begin
            code_s = CODE_BAD_OP;
        end else if (cmd_r.t) begin
            code_s = CODE_ADDR;
        end else if (cmd_r.pl > 3'd2) begin
            code_s = CODE_BAD_OP;
        end else if (!is_aligned(cmd_r.pl, off_s)) begin
            code_s = CODE_ALIGN;
        end else if ({22'd0, word_s} >= 32'(NUM_REGS)) begin
            code_s = CODE_ADDR;
        end else if (bdi_fail_s) begin
            code_s = CODE_BAD_DATA;
        end else begin
            fail_s = 1'b0;
        end
    end

    // Response opcode and data for the command in EXEC.
    always_comb begin
        resp_op_s = OP_RD_FAIL;
        rdata_s   = 32'h0;
        if (fail_s) begin
            resp_op_s = is_write_s ? OP_WR_FAIL : OP_RD_FAIL;
        end else if (is_write_s) begin
            resp_op_s = OP_WR_RESP;
        end else begin
            resp_op_s = OP_RD_RESP;
            rdata_s   = rd_word_s;
        end
    end

    // Reg 0 holds the read-only ID; writes to it succeed without effect.
    assign wr_en_s = (state_r == EXEC) && !fail_s && is_write_s && (word_s != 10'd0);

    // FSM state register.
    always_ff @(posedge tlx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: pop in IDLE, one EXEC cycle, hold RESP until ack.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) state_next_s = EXEC;
                else       state_next_s = IDLE;
            end
            EXEC: state_next_s = RESP;
            RESP: begin
                if (tlx_cfg0_resp_ack) state_next_s = IDLE;
                else                   state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Command being executed, captured as it leaves the queue.
    always_ff @(posedge tlx_clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_r <= '0;
        end else if (pop_s) begin
            cmd_r <= head_s;
        end
    end

    // Register file with byte-lane merge on successful writes.
    always_ff @(posedge tlx_clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_r[0] <= ID_VALUE;
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_r[r] <= 32'h0;
            end
        end else if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask_s[b]) begin
                    regs_r[word_s[IW-1:0]][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Response registers: loaded at end of EXEC, valid dropped on ack.
    always_ff @(posedge tlx_clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_r <= 1'b0;
            resp_op_r    <= 8'h0;
            resp_tag_r   <= 16'h0;
            resp_code_r  <= 4'h0;
            rdata_off_r  <= 4'h0;
            rdata_r      <= 32'h0;
        end else if (state_r == EXEC) begin
            resp_valid_r <= 1'b1;
            resp_op_r    <= resp_op_s;
            resp_tag_r   <= cmd_r.capptag;
            resp_code_r  <= code_s;
            rdata_off_r  <= (cmd_r.opcode == OP_CONFIG_READ) ? {2'b00, off_s} : 4'h0;
            rdata_r      <= rdata_s;
        end else if ((state_r == RESP) && tlx_cfg0_resp_ack) begin
            resp_valid_r <= 1'b0;
        end
    end

    // Sticky overflow flag: command arrived with no slot free.
    always_ff @(posedge tlx_clock or negedge reset_n) begin
        if (!reset_n) begin
            protocol_err_r <= 1'b0;
        end else if (tlx_cfg0_valid && full_s && !pop_s) begin
            protocol_err_r <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[32*g +: 32] = regs_r[g];
    end

    assign cfg0_tlx_initial_credit = 4'(FIFO_DEPTH);
    assign cfg0_tlx_credit_return  = pop_s;
    assign cfg0_tlx_resp_valid     = resp_valid_r;
    assign cfg0_tlx_resp_opcode    = resp_op_r;
    assign cfg0_tlx_resp_capptag   = resp_tag_r;
    assign cfg0_tlx_resp_code      = resp_code_r;
    assign cfg0_tlx_rdata_offset   = rdata_off_r;
    assign cfg0_tlx_rdata_bus      = rdata_r;
    assign cfg0_tlx_rdata_bdi      = 1'b0;
    assign protocol_err            = protocol_err_r;

endmodule

// File: tb/tb_afu_cfg0_responder.sv
// Directed self-checking bench for afu_cfg0_responder (default parameters).
// Honours CFG0_BDI_CHECK_EN when choosing expectations for bad-data writes.
module tb_afu_cfg0_responder;

    localparam logic [31:0] ID = 32'h1014_0632;

    logic         tlx_clock = 1'b0;
    logic         reset_n;
    logic         tlx_cfg0_valid;
    logic [7:0]   tlx_cfg0_opcode;
    logic [63:0]  tlx_cfg0_pa;
    logic         tlx_cfg0_t;
    logic [2:0]   tlx_cfg0_pl;
    logic [15:0]  tlx_cfg0_capptag;
    logic [31:0]  tlx_cfg0_data_bus;
    logic         tlx_cfg0_data_bdi;
    logic         tlx_cfg0_resp_ack;
    logic [3:0]   cfg0_tlx_initial_credit;
    logic         cfg0_tlx_credit_return;
    logic         cfg0_tlx_resp_valid;
    logic [7:0]   cfg0_tlx_resp_opcode;
    logic [15:0]  cfg0_tlx_resp_capptag;
    logic [3:0]   cfg0_tlx_resp_code;
    logic [3:0]   cfg0_tlx_rdata_offset;
    logic [31:0]  cfg0_tlx_rdata_bus;
    logic         cfg0_tlx_rdata_bdi;
    logic [511:0] cfg_regs;
    logic         protocol_err;

    int checks = 0;
    int errors = 0;
    int credit_cnt = 0;

    logic [7:0]  r_op;
    logic [15:0] r_tag;
    logic [3:0]  r_code;
    logic [3:0]  r_off;
    logic [31:0] r_rdata;
    int          r_lat;

    afu_cfg0_responder dut (
        .tlx_clock               (tlx_clock),
        .reset_n                 (reset_n),
        .tlx_cfg0_valid          (tlx_cfg0_valid),
        .tlx_cfg0_opcode         (tlx_cfg0_opcode),
        .tlx_cfg0_pa             (tlx_cfg0_pa),
        .tlx_cfg0_t              (tlx_cfg0_t),
        .tlx_cfg0_pl             (tlx_cfg0_pl),
        .tlx_cfg0_capptag        (tlx_cfg0_capptag),
        .tlx_cfg0_data_bus       (tlx_cfg0_data_bus),
        .tlx_cfg0_data_bdi       (tlx_cfg0_data_bdi),
        .tlx_cfg0_resp_ack       (tlx_cfg0_resp_ack),
        .cfg0_tlx_initial_credit (cfg0_tlx_initial_credit),
        .cfg0_tlx_credit_return  (cfg0_tlx_credit_return),
        .cfg0_tlx_resp_valid     (cfg0_tlx_resp_valid),
        .cfg0_tlx_resp_opcode    (cfg0_tlx_resp_opcode),
        .cfg0_tlx_resp_capptag   (cfg0_tlx_resp_capptag),
        .cfg0_tlx_resp_code      (cfg0_tlx_resp_code),
        .cfg0_tlx_rdata_offset   (cfg0_tlx_rdata_offset),
        .cfg0_tlx_rdata_bus      (cfg0_tlx_rdata_bus),
        .cfg0_tlx_rdata_bdi      (cfg0_tlx_rdata_bdi),
        .cfg_regs                (cfg_regs),
        .protocol_err            (protocol_err)
    );

    always #5 tlx_clock = ~tlx_clock;

    // Count credit pulses mid-cycle.
    always @(negedge tlx_clock) begin
        if (cfg0_tlx_credit_return === 1'b1) credit_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] op, input logic [63:0] pa, input logic t,
                         input logic [2:0] pl, input logic [15:0] tag,
                         input logic [31:0] data, input logic bdi);
        tlx_cfg0_opcode   = op;
        tlx_cfg0_pa       = pa;
        tlx_cfg0_t        = t;
        tlx_cfg0_pl       = pl;
        tlx_cfg0_capptag  = tag;
        tlx_cfg0_data_bus = data;
        tlx_cfg0_data_bdi = bdi;
        tlx_cfg0_valid    = 1'b1;
    endtask

    task automatic send(input logic [7:0] op, input logic [63:0] pa, input logic t,
                        input logic [2:0] pl, input logic [15:0] tag,
                        input logic [31:0] data, input logic bdi);
        drive(op, pa, t, pl, tag, data, bdi);
        @(negedge tlx_clock);
        tlx_cfg0_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, capture it, optionally acknowledge it.
    // A timeout yields an impossible opcode/tag so the caller's checks fail.
    task automatic collect(input bit do_ack);
        r_lat = 0;
        while (cfg0_tlx_resp_valid !== 1'b1 && r_lat < 40) begin
            @(negedge tlx_clock);
            tlx_cfg0_valid = 1'b0;
            r_lat++;
        end
        if (cfg0_tlx_resp_valid !== 1'b1) begin
            $display("FAIL resp_timeout: no response within %0d cycles", r_lat);
            r_op  = 8'hFF;
            r_tag = 16'hFFFF;
        end else begin
            r_op    = cfg0_tlx_resp_opcode;
            r_tag   = cfg0_tlx_resp_capptag;
            r_code  = cfg0_tlx_resp_code;
            r_off   = cfg0_tlx_rdata_offset;
            r_rdata = cfg0_tlx_rdata_bus;
            if (do_ack) begin
                tlx_cfg0_resp_ack = 1'b1;
                @(negedge tlx_clock);
                tlx_cfg0_resp_ack = 1'b0;
            end
        end
    endtask

    task automatic do_txn(input logic [7:0] op, input logic [63:0] pa, input logic t,
                          input logic [2:0] pl, input logic [15:0] tag,
                          input logic [31:0] data, input logic bdi);
        drive(op, pa, t, pl, tag, data, bdi);
        collect(1'b1);
    endtask

    task automatic test_reset();
        logic [479:0] upper;
        reset_n = 1'b0;
        tlx_cfg0_valid = 1'b0; tlx_cfg0_resp_ack = 1'b0;
        drive(8'h00, 64'h0, 1'b0, 3'd0, 16'h0, 32'h0, 1'b0);
        tlx_cfg0_valid = 1'b0;
        repeat (3) @(negedge tlx_clock);
        reset_n = 1'b1;
        @(negedge tlx_clock);
        upper = cfg_regs[511:32];
        checks++; if (cfg0_tlx_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", cfg0_tlx_resp_valid); end
        checks++; if (cfg0_tlx_initial_credit !== 4'd4) begin errors++; $display("FAIL rst_initial_credit: got %0d exp 4", cfg0_tlx_initial_credit); end
        checks++; if (cfg_regs[31:0] !== ID) begin errors++; $display("FAIL rst_reg0: got %h exp %h", cfg_regs[31:0], ID); end
        checks++; if (upper !== 480'h0) begin errors++; $display("FAIL rst_regs_zero: got nonzero upper regs"); end
        checks++; if (protocol_err !== 1'b0 || cfg0_tlx_credit_return !== 1'b0 || cfg0_tlx_rdata_bus !== 32'h0)
            begin errors++; $display("FAIL rst_misc: perr=%b credit=%b rdata=%h exp 0/0/0", protocol_err, cfg0_tlx_credit_return, cfg0_tlx_rdata_bus); end
    endtask

    task automatic test_write_read();
        int base = credit_cnt;
        do_txn(8'hE1, 64'h004, 1'b0, 3'd2, 16'h0011, 32'hDEADBEEF, 1'b0);
        checks++; if (r_op !== 8'h04 || r_code !== 4'h0 || r_tag !== 16'h0011)
            begin errors++; $display("FAIL wr_resp: got op=%h code=%h tag=%h exp 04/0/0011", r_op, r_code, r_tag); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL latency: got %0d exp 3", r_lat); end
        checks++; if (credit_cnt - base !== 1) begin errors++; $display("FAIL credit_one: got %0d exp 1", credit_cnt - base); end
        checks++; if (cfg_regs[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL reg1_write: got %h exp DEADBEEF", cfg_regs[63:32]); end
        do_txn(8'hE0, 64'h004, 1'b0, 3'd2, 16'h0012, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h01 || r_code !== 4'h0 || r_tag !== 16'h0012 || r_rdata !== 32'hDEADBEEF || r_off !== 4'h0)
            begin errors++; $display("FAIL rd_resp: got op=%h code=%h tag=%h data=%h off=%h exp 01/0/0012/DEADBEEF/0", r_op, r_code, r_tag, r_rdata, r_off); end
    endtask

    task automatic test_partial();
        do_txn(8'hE1, 64'h009, 1'b0, 3'd0, 16'h0021, 32'h000000AA, 1'b0);
        checks++; if (r_op !== 8'h04 || r_code !== 4'h0) begin errors++; $display("FAIL byte_wr_resp: got %h/%h exp 04/0", r_op, r_code); end
        checks++; if (cfg_regs[95:64] !== 32'h0000AA00) begin errors++; $display("FAIL byte_merge: got %h exp 0000AA00", cfg_regs[95:64]); end
        do_txn(8'hE0, 64'h00A, 1'b0, 3'd1, 16'h0022, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h01 || r_off !== 4'h2 || r_rdata !== 32'h0000AA00)
            begin errors++; $display("FAIL half_rd: got op=%h off=%h data=%h exp 01/2/0000AA00", r_op, r_off, r_rdata); end
    endtask

    task automatic test_errors();
        do_txn(8'hE0, 64'h040, 1'b0, 3'd2, 16'h0031, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h02 || r_code !== 4'hE) begin errors++; $display("FAIL range: got %h/%h exp 02/E", r_op, r_code); end
        do_txn(8'hE1, 64'h006, 1'b0, 3'd2, 16'h0032, 32'h55555555, 1'b0);
        checks++; if (r_op !== 8'h05 || r_code !== 4'hB) begin errors++; $display("FAIL misalign: got %h/%h exp 05/B", r_op, r_code); end
        checks++; if (cfg_regs[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL fail_no_update: got %h exp DEADBEEF", cfg_regs[63:32]); end
        do_txn(8'h20, 64'h000, 1'b0, 3'd2, 16'h0033, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h02 || r_code !== 4'h9 || r_tag !== 16'h0033) begin errors++; $display("FAIL bad_opcode: got %h/%h exp 02/9", r_op, r_code); end
        do_txn(8'hE0, 64'h000, 1'b1, 3'd3, 16'h0034, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h02 || r_code !== 4'hE) begin errors++; $display("FAIL type1_first: got %h/%h exp 02/E", r_op, r_code); end
        do_txn(8'hE0, 64'h000, 1'b0, 3'd3, 16'h0035, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h02 || r_code !== 4'h9) begin errors++; $display("FAIL bad_pl: got %h/%h exp 02/9", r_op, r_code); end
        do_txn(8'hE0, 64'h041, 1'b0, 3'd2, 16'h0036, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h02 || r_code !== 4'hB) begin errors++; $display("FAIL align_before_range: got %h/%h exp 02/B", r_op, r_code); end
        do_txn(8'hE1, 64'h000, 1'b0, 3'd2, 16'h0037, 32'h12345678, 1'b0);
        checks++; if (r_op !== 8'h04 || r_code !== 4'h0 || cfg_regs[31:0] !== ID)
            begin errors++; $display("FAIL reg0_ro: got op=%h code=%h reg0=%h exp 04/0/%h", r_op, r_code, cfg_regs[31:0], ID); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  s_op;
        logic [15:0] s_tag;
        logic [31:0] s_data;
        bit          stable = 1'b1;
        int          base;
        drive(8'hE0, 64'h000, 1'b0, 3'd2, 16'h00A0, 32'h0, 1'b0);
        collect(1'b0);
        checks++; if (r_op !== 8'h01 || r_rdata !== ID) begin errors++; $display("FAIL bp_first: got %h/%h exp 01/%h", r_op, r_rdata, ID); end
        s_op = cfg0_tlx_resp_opcode; s_tag = cfg0_tlx_resp_capptag; s_data = cfg0_tlx_rdata_bus;
        for (int i = 0; i < 4; i++) begin
            send(8'hE1, 64'(12 + 4*i), 1'b0, 3'd2, 16'h00B1 + 16'(i), {4{8'(8'h33 + 8'(i) * 8'h11)}}, 1'b0);
        end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_early: got %b exp 0", protocol_err); end
        for (int c = 0; c < 10; c++) begin
            @(negedge tlx_clock);
            if (cfg0_tlx_resp_valid !== 1'b1 || cfg0_tlx_resp_opcode !== s_op || cfg0_tlx_resp_capptag !== s_tag ||
                cfg0_tlx_rdata_bus !== s_data || cfg0_tlx_credit_return !== 1'b0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL resp_stable: got unstable exp stable"); end
        send(8'hE1, 64'h01C, 1'b0, 3'd2, 16'h00BF, 32'h77777777, 1'b0);
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_overflow: got %b exp 1", protocol_err); end
        base = credit_cnt;
        tlx_cfg0_resp_ack = 1'b1;
        @(negedge tlx_clock);
        tlx_cfg0_resp_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            collect(1'b1);
            checks++; if (r_op !== 8'h04 || r_tag !== 16'h00B1 + 16'(i))
                begin errors++; $display("FAIL bp_order%0d: got op=%h tag=%h exp 04/%h", i, r_op, r_tag, 16'h00B1 + 16'(i)); end
        end
        checks++; if (credit_cnt - base !== 4) begin errors++; $display("FAIL credit_four: got %0d exp 4", credit_cnt - base); end
        checks++; if (cfg_regs[127:96] !== 32'h33333333 || cfg_regs[223:192] !== 32'h66666666)
            begin errors++; $display("FAIL bp_regs: got reg3=%h reg6=%h exp 33333333/66666666", cfg_regs[127:96], cfg_regs[223:192]); end
        checks++; if (cfg_regs[255:224] !== 32'h0) begin errors++; $display("FAIL dropped_cmd: got reg7=%h exp 0", cfg_regs[255:224]); end
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b exp 1", protocol_err); end
    endtask

    task automatic test_bdi();
        logic [7:0]  exp_op;
        logic [3:0]  exp_code;
        logic [31:0] exp_reg;
`ifdef CFG0_BDI_CHECK_EN
        exp_op = 8'h05; exp_code = 4'h8; exp_reg = 32'hDEADBEEF;
`else
        exp_op = 8'h04; exp_code = 4'h0; exp_reg = 32'hCAFEF00D;
`endif
        do_txn(8'hE1, 64'h004, 1'b0, 3'd2, 16'h0051, 32'hCAFEF00D, 1'b1);
        checks++; if (r_op !== exp_op || r_code !== exp_code) begin errors++; $display("FAIL bdi_resp: got %h/%h exp %h/%h", r_op, r_code, exp_op, exp_code); end
        checks++; if (cfg_regs[63:32] !== exp_reg) begin errors++; $display("FAIL bdi_reg: got %h exp %h", cfg_regs[63:32], exp_reg); end
    endtask

    task automatic test_reset_mid();
        int base;
        drive(8'hE0, 64'h008, 1'b0, 3'd2, 16'h0061, 32'h0, 1'b0);
        collect(1'b0);
        checks++; if (r_op !== 8'h01 || r_tag !== 16'h0061) begin errors++; $display("FAIL pre_reset_resp: got %h/%h exp 01/0061", r_op, r_tag); end
        send(8'hE0, 64'h004, 1'b0, 3'd2, 16'h0062, 32'h0, 1'b0);
        base = credit_cnt;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cfg0_tlx_resp_valid !== 1'b0) begin errors++; $display("FAIL async_resp_valid: got %b exp 0", cfg0_tlx_resp_valid); end
        checks++; if (cfg_regs[31:0] !== ID || cfg_regs[63:32] !== 32'h0 || protocol_err !== 1'b0)
            begin errors++; $display("FAIL async_regs: got reg0=%h reg1=%h perr=%b exp %h/0/0", cfg_regs[31:0], cfg_regs[63:32], protocol_err, ID); end
        @(negedge tlx_clock);
        reset_n = 1'b1;
        repeat (5) @(negedge tlx_clock);
        checks++; if (cfg0_tlx_resp_valid !== 1'b0 || credit_cnt - base !== 0)
            begin errors++; $display("FAIL queue_flushed: got valid=%b credits=%0d exp 0/0", cfg0_tlx_resp_valid, credit_cnt - base); end
        do_txn(8'hE0, 64'h000, 1'b0, 3'd2, 16'h0063, 32'h0, 1'b0);
        checks++; if (r_op !== 8'h01 || r_tag !== 16'h0063 || r_rdata !== ID)
            begin errors++; $display("FAIL post_reset_rd: got %h/%h/%h exp 01/0063/%h", r_op, r_tag, r_rdata, ID); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_errors();
        test_back_to_back();
        test_bdi();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
